// File: rtl/adc_pkt_sched.sv
// ---------------------------------------------------------------------------
// adc_pkt_sched
//
// Packet scheduler for the ADC capture path. A start request asks the capture
// writer to fill the sample buffer; the buffer is then read out as fixed-length
// packets framed with SOP/EOP, spaced by a programmable lead-in and
// inter-packet gap, onto the ADC data / data-valid pad interface. An "again"
// request replays the stored buffer without capturing again.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, again             run requests (one-cycle pulses)
//   cfg_len_sel              packet length select: 216/432/864/1728 samples
//   cfg_idle, cfg_gap        lead-in cycles / idle cycles between packets
//   self_test                selects counter data instead of buffer data
//   cap_req, cap_done        capture handshake with the buffer writer
//   rd_en, rd_addr, rd_data  buffer read port (data one cycle after rd_en)
//   out_data, out_valid,
//   out_sop, out_eop         packet stream towards the pad mux
//   busy, done               run in progress / end-of-run pulse
//
// Optional feature: define ADC_PKT_SCHED_SELFTEST_EN to enable the self-test
// counter source. Without it, self_test is ignored.
// ---------------------------------------------------------------------------
module adc_pkt_sched #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 13,
    parameter int BUF_DEPTH = 6912
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              again,
    input  logic [1:0]        cfg_len_sel,
    input  logic [7:0]        cfg_idle,
    input  logic [7:0]        cfg_gap,
    input  logic              self_test,
    output logic              cap_req,
    input  logic              cap_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_LEAD    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    logic [2:0]        state;
    logic              buf_valid;
    logic [1:0]        len_sel_q;
    logic [7:0]        idle_q;
    logic [7:0]        gap_q;
    logic [7:0]        wait_cnt;
    logic [10:0]       smp_idx;
    logic [10:0]       last_idx;
    logic              accept_start;
    logic              accept_again;
    logic              skip_cap;
    logic              pkt_end;
    logic              buf_end;
    logic              v1;
    logic              s1;
    logic              e1;
    logic [DATA_W-1:0] sample;

    // Start always wins over again; again only replays a buffer that holds data.
    assign accept_start = (state == S_IDLE) && start;
    assign accept_again = (state == S_IDLE) && again && buf_valid && !start;
    assign rd_en        = (state == S_SEND);
    assign busy         = (state != S_IDLE);
    assign pkt_end      = (smp_idx == last_idx);
    assign buf_end      = (rd_addr == ADDR_W'(BUF_DEPTH - 1));

    // Index of the last sample in a packet for the latched length select.
    always_comb begin
        last_idx = 11'd215;
        case (len_sel_q)
            2'd1:    last_idx = 11'd431;
            2'd2:    last_idx = 11'd863;
            2'd3:    last_idx = 11'd1727;
            default: last_idx = 11'd215;
        endcase
    end

`ifdef ADC_PKT_SCHED_SELFTEST_EN
    logic              st_mode;
    logic [DATA_W-1:0] st_cnt;

    assign skip_cap = self_test;
    assign sample   = st_mode ? st_cnt : rd_data;

    // Self-test source: the mode is frozen per run and the counter restarts
    // at every accepted run, advancing once per sample reaching the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mode <= 1'b0;
            st_cnt  <= '0;
        end else if (accept_start || accept_again) begin
            st_mode <= self_test;
            st_cnt  <= '0;
        end else if (v1 && st_mode) begin
            st_cnt <= st_cnt + 1'b1;
        end
    end
`else
    logic unused_self_test;

    assign unused_self_test = self_test;
    assign skip_cap         = 1'b0;
    assign sample           = rd_data;
`endif

    // Main sequencer. LEAD and GAP are skipped entirely when their length is
    // zero so that the first SOP lands cfg_idle+3 cycles after the request and
    // packets run back-to-back with cfg_gap=0. The final packet is recognised
    // by the read address reaching the end of the buffer, which works because
    // the buffer depth is a whole number of packets for every length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            buf_valid <= 1'b0;
            cap_req   <= 1'b0;
            rd_addr   <= '0;
            done      <= 1'b0;
            len_sel_q <= 2'd0;
            idle_q    <= 8'd0;
            gap_q     <= 8'd0;
            wait_cnt  <= 8'd0;
            smp_idx   <= 11'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    smp_idx  <= 11'd0;
                    rd_addr  <= '0;
                    if (accept_start || accept_again) begin
                        len_sel_q <= cfg_len_sel;
                        idle_q    <= cfg_idle;
                        gap_q     <= cfg_gap;
                    end
                    if (accept_start && !skip_cap) begin
                        cap_req <= 1'b1;
                        state   <= S_CAPTURE;
                    end else if (accept_start || accept_again) begin
                        buf_valid <= 1'b1;
                        state     <= (cfg_idle == 8'd0) ? S_SEND : S_LEAD;
                    end
                end
                S_CAPTURE: begin
                    if (cap_done) begin
                        buf_valid <= 1'b1;
                        cap_req   <= 1'b0;
                        state     <= (idle_q == 8'd0) ? S_SEND : S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (wait_cnt == idle_q - 8'd1) begin
                        wait_cnt <= 8'd0;
                        state    <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_SEND: begin
                    rd_addr <= rd_addr + 1'b1;
                    if (pkt_end) begin
                        smp_idx <= 11'd0;
                        if (buf_end) begin
                            rd_addr <= '0;
                            state   <= S_FLUSH;
                        end else if (gap_q != 8'd0) begin
                            state <= S_GAP;
                        end
                    end else begin
                        smp_idx <= smp_idx + 11'd1;
                    end
                end
                S_GAP: begin
                    if (wait_cnt == gap_q - 8'd1) begin
                        wait_cnt <= 8'd0;
                        state    <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    if (wait_cnt == 8'd1) begin
                        wait_cnt <= 8'd0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-stage output pipeline: the first stage lines the framing up with the
    // buffer's one-cycle read latency, the second registers the pad outputs.
    // Data is forced to zero whenever the sample is not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            s1        <= 1'b0;
            e1        <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else begin
            v1        <= rd_en;
            s1        <= rd_en && (smp_idx == 11'd0);
            e1        <= rd_en && pkt_end;
            out_valid <= v1;
            out_sop   <= s1;
            out_eop   <= e1;
            out_data  <= v1 ? sample : '0;
        end
    end

endmodule

// File: tb/tb_adc_pkt_sched.sv
// ---------------------------------------------------------------------------
// tb_adc_pkt_sched
//
// Self-checking bench for adc_pkt_sched. A buffer model answers reads one
// cycle after rd_en. Each scenario task pushes the expected sample stream
// into a scoreboard queue when it launches a run; a negedge monitor pops and
// compares every valid output sample, checks the read address sequence and
// the EOP-to-SOP spacing, and records timing for the tasks to check.
// ---------------------------------------------------------------------------
module tb_adc_pkt_sched;

    localparam int DEPTH = 6912;

    typedef struct packed {
        logic [17:0] d;
        logic        sop;
        logic        eop;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        again = 1'b0;
    logic [1:0]  cfg_len_sel = 2'd0;
    logic [7:0]  cfg_idle = 8'd0;
    logic [7:0]  cfg_gap = 8'd0;
    logic        self_test = 1'b0;
    logic        cap_req;
    logic        cap_done = 1'b0;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic [17:0] rd_data = 18'd0;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic        done;

    logic [17:0] mem [0:DEPTH-1];
    smp_t        exp_q [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_addr = 0;
    int exp_gap = 0;
    int first_sop_cyc = -1;
    int last_eop_cyc = -1;
    int done_cyc = -1;
    int sop_count = 0;
    int cap_rise = 0;
    bit cap_prev = 1'b0;
    bit busy_seen = 1'b0;
    bit done_seen = 1'b0;
    bit busy_at_done = 1'b0;
    int pulse_cyc = 0;
    int cd_cyc = 0;

    adc_pkt_sched dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .again      (again),
        .cfg_len_sel(cfg_len_sel),
        .cfg_idle   (cfg_idle),
        .cfg_gap    (cfg_gap),
        .self_test  (self_test),
        .cap_req    (cap_req),
        .cap_done   (cap_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock and cycle counter used for all timing checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en && rd_addr < 13'(DEPTH)) rd_data <= mem[rd_addr];
    end

    // Backstop in case a wait somewhere is not bounded as intended.
    initial begin
        #950000;
        $display("[TB] FAIL watchdog: simulation exceeded cycle limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        smp_t e;
        if (cap_req && !cap_prev) cap_rise++;
        cap_prev = cap_req;
        if (busy) busy_seen = 1'b1;
        if (rd_en) begin
            tests++;
            if (rd_addr !== 13'(exp_addr)) begin
                fails++;
                $display("[TB] FAIL rd_addr: got %0d expected %0d", rd_addr, exp_addr);
            end
            exp_addr++;
        end
        if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_sample: got d=%h at cycle %0d, expected no sample", out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_sop, out_eop} !== {e.d, e.sop, e.eop}) begin
                    fails++;
                    $display("[TB] FAIL sample: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                             out_data, out_sop, out_eop, e.d, e.sop, e.eop);
                end
            end
            if (out_sop) begin
                if (first_sop_cyc < 0) first_sop_cyc = cyc;
                if (last_eop_cyc >= 0) begin
                    tests++;
                    if (cyc - last_eop_cyc !== exp_gap + 1) begin
                        fails++;
                        $display("[TB] FAIL eop_sop_spacing: got %0d expected %0d", cyc - last_eop_cyc, exp_gap + 1);
                    end
                end
                sop_count++;
            end
            if (out_eop) last_eop_cyc = cyc;
        end else begin
            tests++;
            if (out_data !== 18'd0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_output: got d=%h sop=%b eop=%b expected all 0", out_data, out_sop, out_eop);
            end
        end
        if (done) begin
            done_seen    = 1'b1;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    // Advance n cycles, leaving the bench just after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start/again request and note the cycle it was driven in.
    task automatic applyStimulus(input bit s, input bit a);
        start     = s;
        again     = a;
        pulse_cyc = cyc;
        tick(1);
        start = 1'b0;
        again = 1'b0;
    endtask

    task automatic pulse_cap_done();
        cap_done = 1'b1;
        cd_cyc   = cyc;
        tick(1);
        cap_done = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic clear_obs(input int gap);
        exp_q.delete();
        exp_addr      = 0;
        exp_gap       = gap;
        first_sop_cyc = -1;
        last_eop_cyc  = -1;
        done_cyc      = -1;
        sop_count     = 0;
        cap_rise      = 0;
        busy_seen     = 1'b0;
        done_seen     = 1'b0;
        busy_at_done  = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 18'($urandom);
    endtask

    // Expected stream for one complete run of packets of length len.
    task automatic push_run(input int len, input bit counter);
        smp_t e;
        for (int k = 0; k < DEPTH; k++) begin
            e.d   = counter ? 18'(k) : mem[k];
            e.sop = (k % len) == 0;
            e.eop = (k % len) == len - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
        #1;
        ok = done_seen;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        tests++;
        if ({cap_req, rd_en, busy, done} !== 4'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got cap_req/rd_en/busy/done=%b expected 0000", {cap_req, rd_en, busy, done});
        end
        tests++;
        if ({rd_addr, out_data, out_valid, out_sop, out_eop} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: got rd_addr=%0d out_data=%h v/s/e=%b expected all 0",
                     rd_addr, out_data, {out_valid, out_sop, out_eop});
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_capture_run();
        bit ok;
        pulse_reset();
        cfg_len_sel = 2'd2;
        cfg_idle    = 8'd15;
        cfg_gap     = 8'd8;
        clear_obs(8);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        tests++;
        if ({busy, cap_req} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL start_accept: got busy/cap_req=%b expected 11", {busy, cap_req});
        end
        tick(99);
        tests++;
        if ({cap_req, rd_en} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL capture_hold: got cap_req/rd_en=%b expected 10", {cap_req, rd_en});
        end
        fill_mem();
        push_run(864, 1'b0);
        pulse_cap_done();
        wait_done(8000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL capture_done_timeout: got no done expected done within budget");
        end
        tests++;
        if (first_sop_cyc !== cd_cyc + 18) begin
            fails++;
            $display("[TB] FAIL first_sop_latency: got %0d expected %0d", first_sop_cyc - cd_cyc, 18);
        end
        tests++;
        if (sop_count !== 8) begin
            fails++;
            $display("[TB] FAIL capture_packets: got %0d expected 8", sop_count);
        end
        tests++;
        if (done_cyc !== last_eop_cyc + 1 || busy_at_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_timing: got done-eop=%0d busy=%b expected 1 and 0", done_cyc - last_eop_cyc, busy_at_done);
        end
        tests++;
        if (exp_q.size() !== 0 || exp_addr !== DEPTH) begin
            fails++;
            $display("[TB] FAIL capture_count: got left=%0d reads=%0d expected 0 and %0d", exp_q.size(), exp_addr, DEPTH);
        end
        @(negedge clk);
        tests++;
        if ({rd_addr, cap_req} !== 14'd0) begin
            fails++;
            $display("[TB] FAIL after_run: got rd_addr=%0d cap_req=%b expected 0 and 0", rd_addr, cap_req);
        end
        tick(1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        cfg_len_sel = 2'd3;
        cfg_idle    = 8'd0;
        cfg_gap     = 8'd0;
        clear_obs(0);
        push_run(1728, 1'b0);
        applyStimulus(1'b0, 1'b1);
        wait_done(8000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL again_done_timeout: got no done expected done within budget");
        end
        tests++;
        if (first_sop_cyc !== pulse_cyc + 3) begin
            fails++;
            $display("[TB] FAIL again_sop_latency: got %0d expected 3", first_sop_cyc - pulse_cyc);
        end
        tests++;
        if (sop_count !== 4 || cap_rise !== 0) begin
            fails++;
            $display("[TB] FAIL again_run: got packets=%0d captures=%0d expected 4 and 0", sop_count, cap_rise);
        end
        tests++;
        if (exp_q.size() !== 0 || done_cyc !== last_eop_cyc + 1) begin
            fails++;
            $display("[TB] FAIL again_end: got left=%0d done-eop=%0d expected 0 and 1", exp_q.size(), done_cyc - last_eop_cyc);
        end
    endtask

    task automatic test_start_again_collision();
        bit ok;
        cfg_len_sel = 2'd0;
        cfg_idle    = 8'd3;
        cfg_gap     = 8'd2;
        clear_obs(2);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        tests++;
        if ({busy, cap_req} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL start_wins: got busy/cap_req=%b expected 11", {busy, cap_req});
        end
        tick(5);
        fill_mem();
        push_run(216, 1'b0);
        pulse_cap_done();
        cfg_gap     = 8'd5;
        cfg_len_sel = 2'd3;
        for (int i = 0; i < 2000 && sop_count < 2; i++) tick(1);
        tick(50);
        tests++;
        if (rd_en !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_send: got rd_en=%b expected 1", rd_en);
        end
        applyStimulus(1'b1, 1'b0);
        wait_done(8000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL collision_done_timeout: got no done expected done within budget");
        end
        tests++;
        if (sop_count !== 32 || cap_rise !== 1) begin
            fails++;
            $display("[TB] FAIL collision_run: got packets=%0d captures=%0d expected 32 and 1", sop_count, cap_rise);
        end
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("[TB] FAIL collision_left: got %0d expected 0", exp_q.size());
        end
        tick(5);
        tests++;
        if ({busy, cap_req} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL late_start_ignored: got busy/cap_req=%b expected 00", {busy, cap_req});
        end
    endtask

    task automatic test_reset_mid_packet();
        cfg_len_sel = 2'd0;
        cfg_idle    = 8'd2;
        cfg_gap     = 8'd1;
        clear_obs(1);
        push_run(216, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 2000 && sop_count < 3; i++) tick(1);
        tick(100);
        tests++;
        if (sop_count !== 3 || out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reach_packet3: got sops=%0d valid=%b expected 3 and 1", sop_count, out_valid);
        end
        pulse_reset();
        @(negedge clk);
        tests++;
        if ({cap_req, rd_en, rd_addr, out_data, out_valid, out_sop, out_eop, busy, done} !== '0) begin
            fails++;
            $display("[TB] FAIL mid_reset: got rd_en=%b rd_addr=%0d out_data=%h valid=%b busy=%b expected all 0",
                     rd_en, rd_addr, out_data, out_valid, busy);
        end
        exp_q.delete();
        tick(1);
        clear_obs(0);
        applyStimulus(1'b0, 1'b1);
        tick(10);
        tests++;
        if (busy_seen !== 1'b0 || cap_rise !== 0) begin
            fails++;
            $display("[TB] FAIL again_after_reset: got busy_seen=%b captures=%0d expected 0 and 0", busy_seen, cap_rise);
        end
    endtask

    task automatic test_again_no_capture();
        pulse_reset();
        clear_obs(0);
        applyStimulus(1'b0, 1'b1);
        tick(10);
        tests++;
        if (busy_seen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL again_ignored_busy: got busy_seen=%b expected 0", busy_seen);
        end
        tests++;
        if (cap_rise !== 0) begin
            fails++;
            $display("[TB] FAIL again_ignored_cap: got captures=%0d expected 0", cap_rise);
        end
    endtask

`ifdef ADC_PKT_SCHED_SELFTEST_EN
    task automatic test_selftest();
        bit ok;
        pulse_reset();
        self_test   = 1'b1;
        cfg_len_sel = 2'd0;
        cfg_idle    = 8'd4;
        cfg_gap     = 8'd3;
        clear_obs(3);
        push_run(216, 1'b1);
        applyStimulus(1'b1, 1'b0);
        self_test = 1'b0;
        wait_done(9000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL selftest_done_timeout: got no done expected done within budget");
        end
        tests++;
        if (sop_count !== 32 || cap_rise !== 0) begin
            fails++;
            $display("[TB] FAIL selftest_run: got packets=%0d captures=%0d expected 32 and 0", sop_count, cap_rise);
        end
        tests++;
        if (first_sop_cyc !== pulse_cyc + 7 || exp_q.size() !== 0) begin
            fails++;
            $display("[TB] FAIL selftest_timing: got sop_lat=%0d left=%0d expected 7 and 0", first_sop_cyc - pulse_cyc, exp_q.size());
        end
    endtask
`endif

    // Scenario sequence.
    initial begin
        test_reset();
        test_capture_run();
        test_back_to_back();
        test_start_again_collision();
        test_reset_mid_packet();
        test_again_no_capture();
`ifdef ADC_PKT_SCHED_SELFTEST_EN
        test_selftest();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
